data_mem_responder: RTL and testbench

//  Responder (slave) end of the ALU data-memory port. It accepts a load or store

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Responder end of the ALU data-memory port. Accepts a load or
//               store request, inserts WAIT_CYC wait states, then completes
//               it with a four-phase handshake on mem_ack / mem_err / dout.
//               Single clock domain, 32-bit word storage of 2**ADDR_W words.
// Ports       : clk      in   system clock, rising edge
//               rst      in   asynchronous reset, active-low
//               mem_ref  in   request strobe, held until mem_ack/mem_err seen
//               rw_mem   in   1 = store, 0 = load (sampled at acceptance)
//               mem_addr in   byte address (sampled at acceptance)
//               din      in   store data (sampled at acceptance)
//               dout     out  load data, valid while mem_ack=1 on a load
//               mem_ack  out  transaction completed successfully
//               mem_err  out  transaction rejected (bad address)
//               busy     out  responder is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ref,
    input  logic        rw_mem,
    input  logic [31:0] mem_addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        busy
);

    localparam int         c_depth     = 2 ** ADDR_W;
    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_wait      = 2'd1;
    localparam logic [1:0] c_resp      = 2'd2;
    localparam logic [3:0] c_wait_init = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [31:0]       r_addr;
    logic [31:0]       r_din;
    logic [31:0]       r_dout;
    logic              r_ack;
    logic              r_err;
    logic [31:0]       r_mem [0:c_depth-1];

    logic              w_addr_err;
    logic [ADDR_W-1:0] w_idx;
    logic              w_access;

    // Misaligned or beyond the implemented word range.
    assign w_addr_err = (r_addr[1:0] != 2'b00) || (|r_addr[31:ADDR_W+2]);
    assign w_idx      = r_addr[ADDR_W+1:2];

    // The access happens on the first edge spent in RESP, which is what
    // places mem_ack at acceptance + WAIT_CYC + 1. If the requester has
    // already withdrawn mem_ref by then, the access is abandoned like a
    // WAIT-state abort.
    assign w_access = (r_state == c_resp) && !(r_ack || r_err) && mem_ref;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (mem_ref) begin
                    w_next_state = (WAIT_CYC == 0) ? c_resp : c_wait;
                end
            end
            c_wait: begin
                if (!mem_ref) begin
                    w_next_state = c_idle;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = c_resp;
                end
            end
            c_resp: begin
                if (!mem_ref) begin
                    w_next_state = c_idle;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request capture, wait counter and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_addr  <= 32'd0;
            r_din   <= 32'd0;
            r_dout  <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == c_idle) && mem_ref) begin
                r_rw   <= rw_mem;
                r_addr <= mem_addr;
                r_din  <= din;
                r_cnt  <= c_wait_init;
            end else if ((r_state == c_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                if (w_addr_err) begin
                    r_err  <= 1'b1;
                    r_dout <= 32'd0;
                end else begin
                    r_ack <= 1'b1;
                    if (!r_rw) begin
                        r_dout <= r_mem[w_idx];
                    end
                end
            end else if ((r_state == c_resp) && !mem_ref) begin
                r_ack <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset. A reset forces r_state to idle
    // asynchronously, so a store that has not reached RESP never writes.
    always_ff @(posedge clk) begin
        if (w_access && r_rw && !w_addr_err) begin
            r_mem[w_idx] <= r_din;
        end
    end

    assign dout    = r_dout;
    assign mem_ack = r_ack;
    assign mem_err = r_err;
    assign busy    = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A default build
//               (WAIT_CYC=2) runs a table of transactions plus hand-written
//               hold, abort and reset sequences; a second build with
//               WAIT_CYC=0 checks the shortest latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dout;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        mem_ref, rw_mem;
    logic [31:0] mem_addr, din, dout;
    logic        mem_ack, mem_err, busy;

    logic        mem_ref0, rw_mem0;
    logic [31:0] mem_addr0, din0, dout0;
    logic        mem_ack0, mem_err0, busy0;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[$];

    data_mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mem_ref  (mem_ref),
        .rw_mem   (rw_mem),
        .mem_addr (mem_addr),
        .din      (din),
        .dout     (dout),
        .mem_ack  (mem_ack),
        .mem_err  (mem_err),
        .busy     (busy)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYC(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .mem_ref  (mem_ref0),
        .rw_mem   (rw_mem0),
        .mem_addr (mem_addr0),
        .din      (din0),
        .dout     (dout0),
        .mem_ack  (mem_ack0),
        .mem_err  (mem_err0),
        .busy     (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic ack, input logic err, input logic [31:0] d, input int lat);
        exp_t e;
        e.ack  = ack;
        e.err  = err;
        e.dout = d;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge with mem_ref released and
    // the responder back in IDLE. hold = extra cycles mem_ref stays high
    // after the response appears.
    task automatic run_req(input bit sel, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data, input int hold, input string name);
        int   n;
        bit   got;
        exp_t e;
        if (sel) begin
            mem_ref0 = 1'b1; rw_mem0 = rw; mem_addr0 = addr; din0 = data;
        end else begin
            mem_ref  = 1'b1; rw_mem  = rw; mem_addr  = addr; din  = data;
        end
        @(posedge clk);
        #1;
        // Post-acceptance input changes must not matter.
        if (sel) begin
            rw_mem0 = ~rw; mem_addr0 = ~addr; din0 = ~data;
        end else begin
            rw_mem  = ~rw; mem_addr  = ~addr; din  = ~data;
        end
        n   = 0;
        got = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (sel ? (mem_ack0 | mem_err0) : (mem_ack | mem_err)) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no response expected response after %0d cycles", name, e.lat);
        end else begin
            chk({name, "_lat"},  n, e.lat);
            chk({name, "_ack"},  sel ? mem_ack0 : mem_ack, e.ack);
            chk({name, "_err"},  sel ? mem_err0 : mem_err, e.err);
            chk({name, "_dout"}, sel ? dout0 : dout, e.dout);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_hold_ack"},  sel ? mem_ack0 : mem_ack, e.ack);
            chk({name, "_hold_busy"}, sel ? busy0 : busy, 1'b1);
        end
        if (sel) mem_ref0 = 1'b0; else mem_ref = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_rel_ack"},  sel ? mem_ack0 : mem_ack, 1'b0);
        chk({name, "_rel_err"},  sel ? mem_err0 : mem_err, 1'b0);
        chk({name, "_rel_busy"}, sel ? busy0 : busy, 1'b0);
    endtask

    task automatic add_vec(input logic rw, input logic [31:0] a, input logic [31:0] d,
                           input logic ack, input logic err, input logic [31:0] ed);
        vec_t v;
        v.rw = rw; v.addr = a; v.data = d;
        v.exp_ack = ack; v.exp_err = err; v.exp_dout = ed;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //        rw    addr          data          ack   err   dout
        add_vec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000);
        add_vec(1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0, 32'hDEAD_BEEF);
        add_vec(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hDEAD_BEEF);
        add_vec(1'b1, 32'h0000_0020, 32'h1111_2222, 1'b1, 1'b0, 32'hDEAD_BEEF);
        add_vec(1'b1, 32'h0000_0008, 32'h0000_A5A5, 1'b1, 1'b0, 32'hDEAD_BEEF);
        add_vec(1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000);
        add_vec(1'b1, 32'h0000_1000, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0000);
        add_vec(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'hCAFE_F00D);
        add_vec(1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b1, 1'b0, 32'hCAFE_F00D);
        add_vec(1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678);
        add_vec(1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000);
        add_vec(1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1, 1'b0, 32'h1111_2222);

        rst = 1'b0;
        mem_ref  = 1'b0; rw_mem  = 1'b0; mem_addr  = 32'd0; din  = 32'd0;
        mem_ref0 = 1'b0; rw_mem0 = 1'b0; mem_addr0 = 32'd0; din0 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ack",  mem_ack, 1'b0);
        chk("reset_err",  mem_err, 1'b0);
        chk("reset_busy", busy,    1'b0);
        chk("reset_dout", dout,    32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven transactions on the WAIT_CYC=2 build.
        foreach (vecs[i]) begin
            push_exp(vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_dout, 3);
            run_req(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].data, 0, $sformatf("vec%0d", i));
        end

        // Hold mem_ref five cycles past the ack; the store must happen once
        // with the latched data, not the scrambled din seen while holding.
        push_exp(1'b1, 1'b0, 32'h1111_2222, 3);
        run_req(1'b0, 1'b1, 32'h0000_0030, 32'hAAAA_0001, 5, "hold_st");
        push_exp(1'b1, 1'b0, 32'hAAAA_0001, 3);
        run_req(1'b0, 1'b0, 32'h0000_0030, 32'h0, 0, "hold_ld");

        // Abort in WAIT: no ack, busy falls on the next edge, no write.
        mem_ref = 1'b1; rw_mem = 1'b1; mem_addr = 32'h0000_0020; din = 32'h9999_9999;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_wait", busy, 1'b1);
        mem_ref = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_fall", busy, 1'b0);
        chk("abort_ack", mem_ack, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_ack_late", mem_ack, 1'b0);
        push_exp(1'b1, 1'b0, 32'h1111_2222, 3);
        run_req(1'b0, 1'b0, 32'h0000_0020, 32'h0, 0, "abort_ld");

        // Reset in the middle of WAIT during a store of 0x5 to 0x8.
        mem_ref = 1'b1; rw_mem = 1'b1; mem_addr = 32'h0000_0008; din = 32'h0000_0005;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_busy_pre", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rstw_ack",  mem_ack, 1'b0);
        chk("rstw_err",  mem_err, 1'b0);
        chk("rstw_busy", busy,    1'b0);
        chk("rstw_dout", dout,    32'd0);
        mem_ref = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        push_exp(1'b1, 1'b0, 32'h0000_A5A5, 3);
        run_req(1'b0, 1'b0, 32'h0000_0008, 32'h0, 0, "rstw_ld");

        // WAIT_CYC=0 build: response one edge after acceptance.
        push_exp(1'b1, 1'b0, 32'h0000_0000, 1);
        run_req(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0077, 0, "w0_st");
        push_exp(1'b1, 1'b0, 32'h0000_0077, 1);
        run_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 0, "w0_ld");
        push_exp(1'b0, 1'b1, 32'h0000_0000, 1);
        run_req(1'b1, 1'b0, 32'h0000_0006, 32'h0, 0, "w0_err");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
